// File: rtl/sva_xlate_lookup.sv
// sva_xlate_lookup: pipelined SVA->SPA lookup front-end for the two-way cuckoo
// address map. Hashes the request into one bucket per way, reads both ways from
// the bucket RAM, compares keys and returns hit/miss plus SPA through a small
// response FIFO. Admission is credit based, so the pipeline itself never stalls.
module sva_xlate_lookup #(
    parameter int                    ADDR_WIDTH     = 64,
    parameter int                    LG_NUM_BUCKETS = 27,
    parameter int                    TAG_WIDTH      = 8,
    parameter int                    FIFO_DEPTH     = 4,
    parameter logic [ADDR_WIDTH-1:0] COE_A0         = 64'h9E3779B97F4A7C15,
    parameter logic [ADDR_WIDTH-1:0] COE_B0         = 64'h9E3779B97F4A7C15,
    parameter logic [ADDR_WIDTH-1:0] COE_A1         = 64'hC2B2AE3D27D4EB4F,
    parameter logic [ADDR_WIDTH-1:0] COE_B1         = 64'hC2B2AE3D27D4EB4F
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cfg_we,
    input  logic                      cfg_way,
    input  logic [ADDR_WIDTH-1:0]     cfg_coe_a,
    input  logic [ADDR_WIDTH-1:0]     cfg_coe_b,
    output logic                      cfg_ready,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [ADDR_WIDTH-1:0]     req_sva,
    input  logic [TAG_WIDTH-1:0]      req_tag,
    output logic                      tbl_rd_en,
    output logic [LG_NUM_BUCKETS-1:0] tbl_rd_idx0,
    output logic [LG_NUM_BUCKETS-1:0] tbl_rd_idx1,
    input  logic [ADDR_WIDTH-1:0]     tbl_key0,
    input  logic [ADDR_WIDTH-1:0]     tbl_key1,
    input  logic [ADDR_WIDTH-1:0]     tbl_val0,
    input  logic [ADDR_WIDTH-1:0]     tbl_val1,
    input  logic                      tbl_vld0,
    input  logic                      tbl_vld1,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_hit,
    output logic                      rsp_way,
    output logic [ADDR_WIDTH-1:0]     rsp_spa,
    output logic [TAG_WIDTH-1:0]      rsp_tag,
    output logic [31:0]               stat_hits,
    output logic [31:0]               stat_misses
);

    localparam int HALF = ADDR_WIDTH / 2;
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = PW + 1;
    localparam int EW   = 2 + ADDR_WIDTH + TAG_WIDTH;
    localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

    logic [ADDR_WIDTH-1:0] coe_a0, coe_b0, coe_a1, coe_b1;

    logic                  s0_vld, s1_vld, s2_vld;
    logic [ADDR_WIDTH-1:0] s0_sva, s1_sva, s2_sva;
    logic [TAG_WIDTH-1:0]  s0_tag, s1_tag, s2_tag;

    logic                  req_fire, cfg_fire, pop;
    logic [CW:0]           occ;

    logic                  hit0, hit1, cmp_hit, cmp_way;
    logic [ADDR_WIDTH-1:0] cmp_spa;

    logic [EW-1:0]         fifo_mem [FIFO_DEPTH];
    logic [EW-1:0]         head;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;

    // Multiply-shift hash: (upper*a + lower*b) mod 2^AW, top LG bits.
    function automatic logic [LG_NUM_BUCKETS-1:0] bucket_idx(
        input logic [ADDR_WIDTH-1:0] sva,
        input logic [ADDR_WIDTH-1:0] a,
        input logic [ADDR_WIDTH-1:0] b
    );
        logic [ADDR_WIDTH-1:0] up, lo, h;
        up = {{HALF{1'b0}}, sva[ADDR_WIDTH-1:HALF]};
        lo = {{HALF{1'b0}}, sva[HALF-1:0]};
        h  = up * a + lo * b;
        return h[ADDR_WIDTH-1 -: LG_NUM_BUCKETS];
    endfunction

    // Admission: credits cover every in-flight stage plus buffered responses,
    // so an S2 result always finds FIFO space; coefficient writes only land
    // when nothing is in flight and block admission in their own cycle.
    always_comb begin
        cfg_ready = !s0_vld && !s1_vld && !s2_vld;
        cfg_fire  = cfg_we && cfg_ready;
        occ       = (CW+1)'(s0_vld) + (CW+1)'(s1_vld) + (CW+1)'(s2_vld) + (CW+1)'(count);
        req_ready = !rst && (occ < DEPTH_C) && !cfg_fire;
        req_fire  = req_valid && req_ready;
    end

    // Hash coefficient registers, reloaded from parameters on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coe_a0 <= COE_A0;
            coe_b0 <= COE_B0;
            coe_a1 <= COE_A1;
            coe_b1 <= COE_B1;
        end else if (cfg_fire) begin
            if (cfg_way) begin
                coe_a1 <= cfg_coe_a;
                coe_b1 <= cfg_coe_b;
            end else begin
                coe_a0 <= cfg_coe_a;
                coe_b0 <= cfg_coe_b;
            end
        end
    end

    // Three-stage pipeline: capture, hash/read strobe, compare against RAM data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_vld      <= 1'b0;
            s0_sva      <= '0;
            s0_tag      <= '0;
            s1_vld      <= 1'b0;
            s1_sva      <= '0;
            s1_tag      <= '0;
            tbl_rd_idx0 <= '0;
            tbl_rd_idx1 <= '0;
            s2_vld      <= 1'b0;
            s2_sva      <= '0;
            s2_tag      <= '0;
        end else begin
            s0_vld <= req_fire;
            if (req_fire) begin
                s0_sva <= req_sva;
                s0_tag <= req_tag;
            end
            s1_vld <= s0_vld;
            s1_sva <= s0_sva;
            s1_tag <= s0_tag;
            if (s0_vld) begin
                tbl_rd_idx0 <= bucket_idx(s0_sva, coe_a0, coe_b0);
                tbl_rd_idx1 <= bucket_idx(s0_sva, coe_a1, coe_b1);
            end
            s2_vld <= s1_vld;
            s2_sva <= s1_sva;
            s2_tag <= s1_tag;
        end
    end

    assign tbl_rd_en = s1_vld;

    // Key compare on returned RAM data; way 0 has priority when both match.
    always_comb begin
        hit0    = tbl_vld0 && (tbl_key0 == s2_sva);
        hit1    = tbl_vld1 && (tbl_key1 == s2_sva);
        cmp_hit = hit0 || hit1;
        cmp_way = !hit0 && hit1;
        cmp_spa = '0;
        if (hit0) begin
            cmp_spa = tbl_val0;
        end else if (hit1) begin
            cmp_spa = tbl_val1;
        end
    end

    assign pop = rsp_valid && rsp_ready;

    // Response FIFO storage; contents need no reset since outputs are gated.
    always_ff @(posedge clk) begin
        if (s2_vld) begin
            fifo_mem[wr_ptr] <= {cmp_hit, cmp_way, cmp_spa, s2_tag};
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (s2_vld) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (s2_vld && !pop) begin
                count <= count + CW'(1);
            end else if (!s2_vld && pop) begin
                count <= count - CW'(1);
            end
        end
    end

    // Head-of-FIFO response, forced to zero when empty.
    always_comb begin
        rsp_valid = (count != '0);
        head      = rsp_valid ? fifo_mem[rd_ptr] : '0;
        {rsp_hit, rsp_way, rsp_spa, rsp_tag} = head;
    end

    // Saturating hit/miss statistics, counted at FIFO push.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
        end else if (s2_vld) begin
            if (cmp_hit && stat_hits != '1) begin
                stat_hits <= stat_hits + 32'd1;
            end
            if (!cmp_hit && stat_misses != '1) begin
                stat_misses <= stat_misses + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_sva_xlate_lookup.sv
// Testbench for sva_xlate_lookup: directed scenarios plus a randomized run,
// checked by a scoreboard fed from a behavioural lookup model.
module tb_sva_xlate_lookup;

    localparam int AW = 64;
    localparam int LG = 4;
    localparam int TW = 8;
    localparam int NB = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cfg_we, cfg_way;
    logic [AW-1:0] cfg_coe_a, cfg_coe_b;
    logic          cfg_ready;
    logic          req_valid, req_ready;
    logic [AW-1:0] req_sva;
    logic [TW-1:0] req_tag;
    logic          tbl_rd_en;
    logic [LG-1:0] tbl_rd_idx0, tbl_rd_idx1;
    logic [AW-1:0] tbl_key0 = '0, tbl_key1 = '0, tbl_val0 = '0, tbl_val1 = '0;
    logic          tbl_vld0 = 1'b0, tbl_vld1 = 1'b0;
    logic          rsp_valid, rsp_ready, rsp_hit, rsp_way;
    logic [AW-1:0] rsp_spa;
    logic [TW-1:0] rsp_tag;
    logic [31:0]   stat_hits, stat_misses;

    always #5 clk = ~clk;

    sva_xlate_lookup #(
        .ADDR_WIDTH(AW),
        .LG_NUM_BUCKETS(LG),
        .TAG_WIDTH(TW),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_way(cfg_way), .cfg_coe_a(cfg_coe_a), .cfg_coe_b(cfg_coe_b),
        .cfg_ready(cfg_ready),
        .req_valid(req_valid), .req_ready(req_ready), .req_sva(req_sva), .req_tag(req_tag),
        .tbl_rd_en(tbl_rd_en), .tbl_rd_idx0(tbl_rd_idx0), .tbl_rd_idx1(tbl_rd_idx1),
        .tbl_key0(tbl_key0), .tbl_key1(tbl_key1), .tbl_val0(tbl_val0), .tbl_val1(tbl_val1),
        .tbl_vld0(tbl_vld0), .tbl_vld1(tbl_vld1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
        .rsp_spa(rsp_spa), .rsp_tag(rsp_tag),
        .stat_hits(stat_hits), .stat_misses(stat_misses)
    );

    typedef struct {
        logic          hit;
        logic          way;
        logic [AW-1:0] spa;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t            exp_q[$];
    logic [2*LG-1:0] idx_q[$];

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference state: bucket RAM contents, coefficients, predicted counters.
    logic [AW-1:0] ram_key [2][NB];
    logic [AW-1:0] ram_val [2][NB];
    logic          ram_vld [2][NB];
    logic [AW-1:0] m_a [2];
    logic [AW-1:0] m_b [2];
    int            m_hits = 0, m_misses = 0;
    bit            bp_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [LG-1:0] ref_idx(input logic [AW-1:0] sva, input logic [AW-1:0] a,
                                              input logic [AW-1:0] b);
        logic [AW-1:0] h;
        h = (sva >> 32) * a + (sva & 64'h0000_0000_FFFF_FFFF) * b;
        return h[AW-1 -: LG];
    endfunction

    task automatic model_defaults();
        m_a[0] = 64'h9E3779B97F4A7C15; m_b[0] = 64'h9E3779B97F4A7C15;
        m_a[1] = 64'hC2B2AE3D27D4EB4F; m_b[1] = 64'hC2B2AE3D27D4EB4F;
    endtask

    task automatic ram_clear();
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < NB; i++) begin
                ram_key[w][i] = '0; ram_val[w][i] = '0; ram_vld[w][i] = 1'b0;
            end
    endtask

    // Synchronous bucket RAM: data appears one cycle after the read strobe.
    always @(posedge clk) begin
        if (tbl_rd_en) begin
            tbl_key0 <= ram_key[0][tbl_rd_idx0];
            tbl_val0 <= ram_val[0][tbl_rd_idx0];
            tbl_vld0 <= ram_vld[0][tbl_rd_idx0];
            tbl_key1 <= ram_key[1][tbl_rd_idx1];
            tbl_val1 <= ram_val[1][tbl_rd_idx1];
            tbl_vld1 <= ram_vld[1][tbl_rd_idx1];
        end
    end

    // Random response back-pressure when enabled.
    initial forever begin
        @(negedge clk);
        if (bp_en) rsp_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on every response handshake and read strobe.
    initial begin
        bit            hold_chk = 0;
        logic          h_hit, h_way;
        logic [AW-1:0] h_spa;
        logic [TW-1:0] h_tag;
        exp_t          e;
        logic [2*LG-1:0] ie;
        forever begin
            @(negedge clk); #2;
            if (rst) begin
                hold_chk = 0;
            end else begin
                if (hold_chk) begin
                    chk("hold_valid", rsp_valid, 1'b1);
                    chk("hold_hit", rsp_hit, h_hit);
                    chk("hold_way", rsp_way, h_way);
                    chk("hold_spa", rsp_spa, h_spa);
                    chk("hold_tag", rsp_tag, h_tag);
                end
                hold_chk = rsp_valid && !rsp_ready;
                h_hit = rsp_hit; h_way = rsp_way; h_spa = rsp_spa; h_tag = rsp_tag;
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        cmp_cnt++; err_cnt++;
                        $display("FAIL rsp_unexpected: actual tag=%h required no response", rsp_tag);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rsp_tag", rsp_tag, e.tag);
                        chk("rsp_hit", rsp_hit, e.hit);
                        chk("rsp_way", rsp_way, e.way);
                        chk("rsp_spa", rsp_spa, e.spa);
                    end
                end
                if (tbl_rd_en) begin
                    if (idx_q.size() == 0) begin
                        cmp_cnt++; err_cnt++;
                        $display("FAIL rd_unexpected: actual rd_en=1 required 0");
                    end else begin
                        ie = idx_q.pop_front();
                        chk("rd_idx0", tbl_rd_idx0, ie[2*LG-1:LG]);
                        chk("rd_idx1", tbl_rd_idx1, ie[LG-1:0]);
                    end
                end
            end
        end
    end

    // Issue one request (starts and ends at a falling edge); predict its result.
    task automatic send(input logic [AW-1:0] sva, input logic [TW-1:0] tag);
        logic [LG-1:0] i0, i1;
        logic          h0, h1;
        exp_t          e;
        bit            done;
        done = 0;
        req_valid = 1'b1; req_sva = sva; req_tag = tag;
        for (int t = 0; t < 200 && !done; t++) begin
            #2;
            if (req_ready) begin
                i0 = ref_idx(sva, m_a[0], m_b[0]);
                i1 = ref_idx(sva, m_a[1], m_b[1]);
                h0 = ram_vld[0][i0] && (ram_key[0][i0] == sva);
                h1 = ram_vld[1][i1] && (ram_key[1][i1] == sva);
                e.hit = h0 || h1;
                e.way = !h0 && h1;
                e.spa = h0 ? ram_val[0][i0] : (h1 ? ram_val[1][i1] : '0);
                e.tag = tag;
                exp_q.push_back(e);
                idx_q.push_back({i0, i1});
                if (e.hit) m_hits++; else m_misses++;
                done = 1;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        if (!done) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL send_timeout: actual req_ready=0 required accept within 200 cycles");
        end
    endtask

    task automatic cfg(input logic way, input logic [AW-1:0] a, input logic [AW-1:0] b);
        bit done;
        done = 0;
        cfg_we = 1'b1; cfg_way = way; cfg_coe_a = a; cfg_coe_b = b;
        for (int t = 0; t < 100 && !done; t++) begin
            #2;
            if (cfg_ready) begin
                m_a[way] = a; m_b[way] = b; done = 1;
            end
            @(negedge clk);
        end
        cfg_we = 1'b0;
        if (!done) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL cfg_timeout: actual cfg_ready=0 required 1 within 100 cycles");
        end
    endtask

    task automatic wait_idle();
        bit done;
        done = 0;
        for (int t = 0; t < 400 && !done; t++) begin
            #2;
            if (exp_q.size() == 0 && cfg_ready && !rsp_valid) done = 1;
            @(negedge clk);
        end
        if (!done) begin
            cmp_cnt++; err_cnt++;
            $display("FAIL drain_timeout: actual pending=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual time limit reached required $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] s1, s4, s5, sva, r;
        logic [AW-1:0] known [12];
        logic [LG-1:0] i0, i1;
        int            lat, acc, ntag, mode;

        rst = 1'b1; cfg_we = 0; cfg_way = 0; cfg_coe_a = '0; cfg_coe_b = '0;
        req_valid = 0; req_sva = '0; req_tag = '0; rsp_ready = 1'b1;
        model_defaults();
        ram_clear();

        // Reset state
        @(negedge clk); #2;
        chk("rst_req_ready", req_ready, 1'b0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_cfg_ready", cfg_ready, 1'b1);
        chk("rst_rd_en", tbl_rd_en, 1'b0);
        chk("rst_idx0", tbl_rd_idx0, 4'h0);
        chk("rst_rsp_spa", rsp_spa, 64'h0);
        chk("rst_hits", stat_hits, 32'h0);
        chk("rst_misses", stat_misses, 32'h0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk); #2;
        chk("post_rst_ready", req_ready, 1'b1);
        @(negedge clk);

        cfg(1'b0, 64'h1 << 32, 64'h0);
        cfg(1'b1, 64'h0, 64'h1 << 32);

        // 1: way-0 hit, latency and read indices
        s1 = 64'hA000_0000_3000_0000;
        ram_key[0][4'hA] = s1; ram_val[0][4'hA] = 64'h1234; ram_vld[0][4'hA] = 1'b1;
        send(s1, 8'h01);
        lat = 0; #2;
        while (!rsp_valid && lat < 10) begin
            if (lat == 1) begin
                chk("t1_rd_en", tbl_rd_en, 1'b1);
                chk("t1_idx0", tbl_rd_idx0, 4'hA);
                chk("t1_idx1", tbl_rd_idx1, 4'h3);
            end
            @(negedge clk); #2;
            lat++;
        end
        chk("t1_latency", lat, 3);
        chk("t1_hit", rsp_hit, 1'b1);
        chk("t1_way", rsp_way, 1'b0);
        chk("t1_spa", rsp_spa, 64'h1234);
        @(negedge clk);
        wait_idle();

        // 2: way-1 hit, then miss on both ways, then both-hit priority
        ram_vld[0][4'hA] = 1'b0;
        ram_key[1][4'h3] = s1; ram_val[1][4'h3] = 64'h55; ram_vld[1][4'h3] = 1'b1;
        send(s1, 8'h02);
        wait_idle();
        ram_vld[0][4'hA] = 1'b1; ram_key[0][4'hA] = s1 ^ 64'h1;
        ram_key[1][4'h3] = s1 ^ 64'h2;
        send(s1, 8'h03);
        wait_idle();
        chk("t2_misses", stat_misses, 32'd1);
        chk("t2_hits", stat_hits, 32'd2);
        ram_key[0][4'hA] = s1; ram_val[0][4'hA] = 64'h77;
        ram_key[1][4'h3] = s1;
        send(s1, 8'h04);
        wait_idle();

        // 3: credit limit with the response side stalled
        rsp_ready = 1'b0;
        acc = 0; ntag = 0;
        for (int c = 0; c < 10; c++) begin
            req_valid = 1'b1; req_sva = {32'h1000_0000 * ntag, 32'h2000_0000}; req_tag = 8'(ntag);
            #2;
            if (req_ready) begin
                i0 = ref_idx(req_sva, m_a[0], m_b[0]);
                i1 = ref_idx(req_sva, m_a[1], m_b[1]);
                exp_q.push_back('{hit: 1'b0, way: 1'b0, spa: '0, tag: 8'(ntag)});
                idx_q.push_back({i0, i1});
                m_misses++; acc++; ntag++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("t3_accepted", acc, 4);
        #2;
        chk("t3_ready_low", req_ready, 1'b0);
        @(negedge clk);
        rsp_ready = 1'b1;
        for (int c = 0; c < 50 && ntag < 6; c++) begin
            send({32'h1000_0000 * ntag, 32'h2000_0000}, 8'(ntag));
            ntag++;
        end
        wait_idle();

        // 4: cfg dropped while busy, then applied when idle
        s4 = 64'h5000_0000_7000_0000;
        send(s4, 8'h20);
        cfg_we = 1'b1; cfg_way = 1'b0; cfg_coe_a = 64'h0; cfg_coe_b = 64'h1 << 32;
        #2;
        chk("t4_cfg_busy", cfg_ready, 1'b0);
        @(negedge clk);
        cfg_we = 1'b0;
        wait_idle();
        send(64'h6000_0000_2000_0000, 8'h21);
        wait_idle();
        s5 = 64'h9000_0000_C000_0000;
        cfg_we = 1'b1; cfg_way = 1'b0; cfg_coe_a = 64'h0; cfg_coe_b = 64'h1 << 32;
        req_valid = 1'b1; req_sva = s5; req_tag = 8'h22;
        #2;
        chk("t4_cfg_ready", cfg_ready, 1'b1);
        chk("t4_req_blocked", req_ready, 1'b0);
        m_a[0] = 64'h0; m_b[0] = 64'h1 << 32;
        @(negedge clk);
        cfg_we = 1'b0;
        send(s5, 8'h22);
        wait_idle();

        // Randomized run with random coefficients and back-pressure
        cfg(1'b0, {$urandom, $urandom}, {$urandom, $urandom});
        cfg(1'b1, {$urandom, $urandom}, {$urandom, $urandom});
        ram_clear();
        for (int k = 0; k < 12; k++) begin
            sva = {$urandom, $urandom};
            i0 = ref_idx(sva, m_a[0], m_b[0]);
            i1 = ref_idx(sva, m_a[1], m_b[1]);
            mode = $urandom_range(0, 2);
            if (mode != 1) begin
                ram_key[0][i0] = sva; ram_val[0][i0] = {$urandom, $urandom}; ram_vld[0][i0] = 1'b1;
            end
            if (mode != 0) begin
                ram_key[1][i1] = sva; ram_val[1][i1] = {$urandom, $urandom}; ram_vld[1][i1] = 1'b1;
            end
            known[k] = sva;
        end
        bp_en = 1;
        for (int n = 0; n < 150; n++) begin
            r = {$urandom, $urandom};
            sva = ($urandom_range(0, 3) == 0) ? r : known[$urandom_range(0, 11)];
            send(sva, 8'(n));
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        bp_en = 0;
        rsp_ready = 1'b1;
        wait_idle();
        chk("rand_hits", stat_hits, 32'(m_hits));
        chk("rand_misses", stat_misses, 32'(m_misses));

        // 5: reset with buffered requests
        rsp_ready = 1'b0;
        send(known[0], 8'h30);
        send(known[1], 8'h31);
        send(known[2], 8'h32);
        repeat (4) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_rsp_valid", rsp_valid, 1'b0);
        chk("t5_hits", stat_hits, 32'h0);
        chk("t5_misses", stat_misses, 32'h0);
        chk("t5_req_ready", req_ready, 1'b0);
        chk("t5_rsp_tag", rsp_tag, 8'h0);
        exp_q.delete();
        idx_q.delete();
        model_defaults();
        m_hits = 0; m_misses = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rsp_ready = 1'b1;
        #2;
        chk("t5_ready_after", req_ready, 1'b1);
        @(negedge clk);
        send(known[3], 8'h40);
        send(64'hDEAD_BEEF_0123_4567, 8'h41);
        wait_idle();
        chk("t5_post_hits", stat_hits, 32'(m_hits));
        chk("t5_post_misses", stat_misses, 32'(m_misses));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
